// File: rtl/nor_reduce_filt.sv
// nor_reduce_filt: masked N-input NOR with optional synchroniser, hold-count qualification,
// sticky latch, rise pulse and violation capture with first-offender index.
module nor_reduce_filt #(
  parameter int N      = 6,
  parameter int HOLD_W = 4,
  parameter int SYNC   = 0,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [N-1:0]      din,
  input  logic [N-1:0]      mask,
  input  logic [HOLD_W-1:0] hold,
  input  logic              sticky,
  output logic              dout,
  output logic              rise,
  output logic              viol,
  output logic [IDX_W-1:0]  fail_idx
);
  logic [N-1:0] din_s, act;
  logic [HOLD_W-1:0] cnt, cnt_n, h;
  logic [HOLD_W:0] inc;
  logic [IDX_W-1:0] idx_n;
  logic q, dout_n;
  generate
    if (SYNC == 2) begin : g_sync
      logic [N-1:0] s1, s2;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= din;
          s2 <= s1;
        end
      assign din_s = s2;
    end else begin : g_nosync
      assign din_s = din;
    end
  endgenerate
  assign act = din_s & ~mask;
  assign q = ~|act;
  // hold=0 qualifies like hold=1
  assign h = (hold == '0) ? HOLD_W'(1) : hold;
  assign inc = {1'b0, cnt} + 1'b1;
  assign cnt_n = !q ? '0 : (inc >= {1'b0, h}) ? h : inc[HOLD_W-1:0];
  assign dout_n = clr ? 1'b0 : !en ? dout : q ? ((cnt_n == h) | dout) : (sticky & dout);
  always_comb begin
    idx_n = '0;
    for (int i = N - 1; i >= 0; i--)
      if (act[i]) idx_n = IDX_W'(i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt      <= '0;
      dout     <= 1'b0;
      rise     <= 1'b0;
      viol     <= 1'b0;
      fail_idx <= '0;
    end else begin
      rise <= dout_n & ~dout;
      dout <= dout_n;
      if (clr) begin
        cnt  <= '0;
        viol <= 1'b0;
      end else if (en) begin
        cnt <= cnt_n;
        if (dout & ~q) begin
          viol     <= 1'b1;
          fail_idx <= idx_n;
        end
      end
    end
endmodule

// File: doc/nor_reduce_filt.md
Name: nor_reduce_filt

Overview:
- Parametrised successor to the fixed 6-input NOR cell: an N-input masked NOR reduction with an optional input synchroniser and a programmable consecutive-cycle qualification filter.
- Adds a sticky-latch mode, a rise pulse, violation capture and first-offender index.
- Used as the "all flags quiet" qualifier, e.g. ADPLL lock and no-error aggregation, feeding control FSMs.

Parameters:
N, 6, number of inputs (N >= 2)
HOLD_W, 4, width of hold count
SYNC, 0, synchroniser depth on din: 0 (none) or 2 (two flops per bit)
IDX_W, $clog2(N), width of fail_idx

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  filter enable; when 0, counter and outputs hold
clr  in  1  synchronous clear of count, dout and viol; priority over en
din  in  N  flag inputs, active-high means "not quiet"
mask  in  N  1 = ignore corresponding din bit
hold  in  HOLD_W  number of consecutive quiet cycles required
sticky  in  1  1 = dout latches high until clr
dout  out  1  qualified NOR result (registered)
rise  out  1  one-cycle pulse on dout 0->1
viol  out  1  sticky: set when unmasked activity seen while dout=1
fail_idx  out  IDX_W  lowest active unmasked index at last violation

Behaviour:
- Reset: dout=0, rise=0, viol=0, fail_idx=0, cnt=0, sync flops=0. Asynchronous assert, synchronous release to clk.
- Synchroniser: din_s is din delayed SYNC cycles. SYNC=0 means din_s=din.
- Quiet term: q = ~|(din_s & ~mask), combinational. mask all-ones forces q=1.
- Counter cnt is HOLD_W bits.
  - cnt_next = q ? min(cnt+1, hold) : 0.
  - Saturates at hold and never wraps.
- dout_next:
  - clr: 0.
  - Otherwise, en=0: dout.
  - Otherwise, q=1 and cnt_next==hold: 1.
  - Otherwise, q=0: (sticky & dout).
  - Otherwise: dout.
- Latency: with hold=H>=1, dout rises on the edge that samples the H-th consecutive quiet cycle, i.e. H cycles after din_s goes quiet. hold=0 behaves as hold=1.
- Falling edge, non-sticky: dout falls on the first edge sampling q=0 (1 cycle).
- Sticky mode: dout stays 1 through q=0 until clr. Counter still resets on q=0.
- rise = registered (dout_next & ~dout). Exactly 1 cycle wide.
- Violation: at an edge with en=1, clr=0, dout=1, q=0:
  - viol is set to 1.
  - fail_idx is set to the lowest i with din_s[i] & ~mask[i].
  - This applies in both modes.
  - viol is cleared only by clr or rst. fail_idx holds until the next violation; clr does not alter it.
- clr and en:
  - clr=1 sets cnt=0, dout=0, viol=0 regardless of en.
  - rise is 0 in a clr cycle.
  - Sync flops still advance.
- en=0: cnt, dout, viol and fail_idx hold; rise=0. Sync flops still advance.
- hold changed mid-count: the new value applies immediately. If cnt >= new hold and q=1, cnt clamps to hold and dout rises next edge.
- Reset mid-qualification: all state cleared immediately; qualification restarts from cnt=0 after release.
- sticky changed 1->0 while dout=1 and q=0: dout falls next edge.

Test Plan:
- N=6, SYNC=0, hold=3, sticky=0: drop din from 6'h01 to 0 at cycle 0 -> dout=1 after edge 3, rise high that cycle only. Then din=6'h04 -> dout=0 next edge, viol=1, fail_idx=2.
- hold=3: din quiet 2 cycles, then 6'h20 for 1 cycle, then quiet -> cnt restarts, dout rises only after 3 further quiet cycles, no rise pulse earlier.
- mask=6'h3C, din=6'h3C constant, hold=1 -> dout=1 after first edge. Then din=6'h02 -> dout=0, fail_idx=1.
- sticky=1, dout=1: pulse din=6'h30 -> dout stays 1, viol=1, fail_idx=4. Assert clr -> dout=0, viol=0, fail_idx=4 retained.
- SYNC=2, hold=0: din quiet at cycle 0 -> dout=1 at edge 3. Assert rst mid-run -> all outputs 0 asynchronously.
- en=0 during count at cnt=2, hold=4: 5 quiet cycles with en low -> dout stays 0. Re-enable -> dout=1 after 2 more edges.
